// File: rtl/read_logic.sv
// Read-side pointer generator for a 4-line x 2048-byte frame buffer ring.
// Drains lines completed by the writer and produces the read address and flow-control status.
module read_logic (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  wr_ptr_tribit,
   input  logic        rd_start,
   input  logic        rd_char_incr,
   input  logic        rd_restart_line,
   input  logic        rd_line_done,
   output logic [2:0]  rd_ptr_tribit,
   output logic [12:0] rd_ptr,
   output logic        rd_busy,
   output logic        line_available,
   output logic        buf_full,
   output logic [2:0]  lines_pending,
   output logic        rd_ovf
);

   localparam int unsigned PTR_W = 3;
   localparam int unsigned OFF_W = 11;
   localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(2047);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   state_e           state_q;
   logic [PTR_W-1:0] rl_q;
   logic [OFF_W-1:0] off_q;
   logic             ovf_q;

   // Occupancy is derived live from the writer pointer so it tracks writer advances immediately.
   assign lines_pending  = PTR_W'(wr_ptr_tribit - rl_q);
   assign line_available = (rl_q != wr_ptr_tribit);
   assign buf_full       = (rl_q[1:0] == wr_ptr_tribit[1:0]) && (rl_q[2] != wr_ptr_tribit[2]);

   assign rd_ptr_tribit = rl_q;
   assign rd_ptr        = {rl_q[1:0], off_q};
   assign rd_busy       = (state_q == ST_ACTIVE);
   assign rd_ovf        = ovf_q;

   // Read FSM; in ACTIVE, line release beats rewind beats increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rl_q    <= '0;
         off_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rd_start && line_available) begin
                  state_q <= ST_ACTIVE;
                  off_q   <= '0;
                  ovf_q   <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (rd_line_done) begin
                  rl_q    <= PTR_W'(rl_q + PTR_W'(1));
                  off_q   <= '0;
                  ovf_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (rd_restart_line) begin
                  off_q <= '0;
                  ovf_q <= 1'b0;
               end else if (rd_char_incr) begin
                  if (off_q != OFF_MAX) begin
                     off_q <= OFF_W'(off_q + OFF_W'(1));
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_read_logic.sv
// Directed self-checking bench for read_logic with hand-computed expected values.
module tb_read_logic;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  wr_ptr_tribit = '0;
   logic        rd_start = 1'b0;
   logic        rd_char_incr = 1'b0;
   logic        rd_restart_line = 1'b0;
   logic        rd_line_done = 1'b0;
   logic [2:0]  rd_ptr_tribit;
   logic [12:0] rd_ptr;
   logic        rd_busy;
   logic        line_available;
   logic        buf_full;
   logic [2:0]  lines_pending;
   logic        rd_ovf;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   read_logic dut (
      .clk            (clk),
      .rst            (rst),
      .wr_ptr_tribit  (wr_ptr_tribit),
      .rd_start       (rd_start),
      .rd_char_incr   (rd_char_incr),
      .rd_restart_line(rd_restart_line),
      .rd_line_done   (rd_line_done),
      .rd_ptr_tribit  (rd_ptr_tribit),
      .rd_ptr         (rd_ptr),
      .rd_busy        (rd_busy),
      .line_available (line_available),
      .buf_full       (buf_full),
      .lines_pending  (lines_pending),
      .rd_ovf         (rd_ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_ptr_tribit = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
   endtask

   task automatic pulse_done();
      rd_line_done = 1'b1;
      tick();
      rd_line_done = 1'b0;
   endtask

   task automatic incr_n(input int n);
      rd_char_incr = 1'b1;
      ticks(n);
      rd_char_incr = 1'b0;
   endtask

   initial begin
      // Reset state
      ticks(2);
      rst = 1'b0;
      check_eq("rst_ptr",     32'(rd_ptr), 32'h0);
      check_eq("rst_tribit",  32'(rd_ptr_tribit), 32'h0);
      check_eq("rst_busy",    32'(rd_busy), 32'h0);
      check_eq("rst_ovf",     32'(rd_ovf), 32'h0);
      check_eq("rst_pending", 32'(lines_pending), 32'h0);
      check_eq("rst_avail",   32'(line_available), 32'h0);
      check_eq("rst_full",    32'(buf_full), 32'h0);

      // Start with nothing available is ignored
      pulse_start();
      check_eq("empty_start_busy",  32'(rd_busy), 32'h0);
      check_eq("empty_start_ptr",   32'(rd_ptr), 32'h0);
      check_eq("empty_start_avail", 32'(line_available), 32'h0);

      // One line: start, 5 increments, release
      wr_ptr_tribit = 3'd1;
      #1;
      check_eq("one_pending", 32'(lines_pending), 32'h1);
      check_eq("one_avail",   32'(line_available), 32'h1);
      incr_n(2);
      check_eq("idle_incr_ignored", 32'(rd_ptr), 32'h0);
      pulse_start();
      check_eq("one_busy",  32'(rd_busy), 32'h1);
      check_eq("one_ptr0",  32'(rd_ptr), 32'h0000);
      incr_n(5);
      check_eq("one_ptr5",  32'(rd_ptr), 32'h0005);
      pulse_done();
      check_eq("one_tribit",  32'(rd_ptr_tribit), 32'h1);
      check_eq("one_busy0",   32'(rd_busy), 32'h0);
      check_eq("one_pending0",32'(lines_pending), 32'h0);
      check_eq("one_ptr_line",32'(rd_ptr), 32'h0800);

      // Full buffer
      do_reset();
      wr_ptr_tribit = 3'd4;
      #1;
      check_eq("full_flag",    32'(buf_full), 32'h1);
      check_eq("full_pending", 32'(lines_pending), 32'h4);
      pulse_start();
      pulse_done();
      check_eq("full_flag_after",    32'(buf_full), 32'h0);
      check_eq("full_pending_after", 32'(lines_pending), 32'h3);
      check_eq("full_tribit_after",  32'(rd_ptr_tribit), 32'h1);

      // Eight line cycles wrap the pointer 7 -> 0
      do_reset();
      for (int i = 0; i < 8; i++) begin
         wr_ptr_tribit = 3'((i + 1) % 8);
         pulse_start();
         if (i == 3) begin
            check_eq("wrap_line3_ptr", 32'(rd_ptr), 32'h1800);
            incr_n(1);
            check_eq("wrap_line3_ptr1", 32'(rd_ptr), 32'h1801);
         end
         pulse_done();
         check_eq("wrap_tribit", 32'(rd_ptr_tribit), 32'((i + 1) % 8));
      end

      // Offset saturation and sticky overflow
      do_reset();
      wr_ptr_tribit = 3'd1;
      pulse_start();
      incr_n(2047);
      check_eq("sat_ptr_max",  32'(rd_ptr), 32'h07FF);
      check_eq("sat_ovf_none", 32'(rd_ovf), 32'h0);
      incr_n(3);
      check_eq("sat_ptr_hold", 32'(rd_ptr), 32'h07FF);
      check_eq("sat_ovf_set",  32'(rd_ovf), 32'h1);
      check_eq("sat_busy",     32'(rd_busy), 32'h1);
      rd_restart_line = 1'b1;
      tick();
      rd_restart_line = 1'b0;
      check_eq("restart_ptr", 32'(rd_ptr), 32'h0);
      check_eq("restart_ovf", 32'(rd_ovf), 32'h0);

      // Restart beats increment
      incr_n(10);
      check_eq("prio_ptr10", 32'(rd_ptr), 32'h000A);
      rd_restart_line = 1'b1;
      rd_char_incr    = 1'b1;
      tick();
      rd_restart_line = 1'b0;
      rd_char_incr    = 1'b0;
      check_eq("prio_restart_incr", 32'(rd_ptr), 32'h0);

      // Line done beats increment
      incr_n(3);
      rd_line_done = 1'b1;
      rd_char_incr = 1'b1;
      tick();
      rd_line_done = 1'b0;
      rd_char_incr = 1'b0;
      check_eq("prio_done_busy",   32'(rd_busy), 32'h0);
      check_eq("prio_done_tribit", 32'(rd_ptr_tribit), 32'h1);
      check_eq("prio_done_ptr",    32'(rd_ptr), 32'h0800);

      // Writer advance coincident with line release
      wr_ptr_tribit = 3'd2;
      pulse_start();
      #1;
      check_eq("coinc_pending_before", 32'(lines_pending), 32'h1);
      wr_ptr_tribit = 3'd3;
      pulse_done();
      check_eq("coinc_pending_after", 32'(lines_pending), 32'h1);
      check_eq("coinc_tribit",        32'(rd_ptr_tribit), 32'h2);

      // Reset while active at 0x0823
      do_reset();
      wr_ptr_tribit = 3'd2;
      pulse_start();
      pulse_done();
      pulse_start();
      incr_n(35);
      check_eq("abort_ptr_pre", 32'(rd_ptr), 32'h0823);
      rst = 1'b1;
      rd_char_incr = 1'b1;
      wr_ptr_tribit = 3'd0;
      tick();
      rst = 1'b0;
      rd_char_incr = 1'b0;
      check_eq("abort_ptr",     32'(rd_ptr), 32'h0);
      check_eq("abort_tribit",  32'(rd_ptr_tribit), 32'h0);
      check_eq("abort_busy",    32'(rd_busy), 32'h0);
      check_eq("abort_ovf",     32'(rd_ovf), 32'h0);
      check_eq("abort_pending", 32'(lines_pending), 32'h0);
      check_eq("abort_full",    32'(buf_full), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
